// File: rtl/sipo_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : sipo_frame_rx
// Brief    : One-bit-per-clock serial frame receiver (start, N data bits LSB
//            first, optional even parity, stop) feeding a one-entry
//            valid/ready holding register. Optional parity: SIPO_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sipo_frame_rx #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         data_in,
    output logic [N-1:0] data_out,
    output logic         valid_out,
    input  logic         ready_in,
    output logic         busy,
    output logic         frame_err,
    output logic         parity_err,
    output logic         overrun
);

    localparam int c_cnt_w = $clog2(N);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(N - 1);

    typedef enum logic [2:0] {
        c_st_idle      = 3'd0,
        c_st_data      = 3'd1,
`ifdef SIPO_RX_PARITY_EN
        c_st_parity    = 3'd2,
`endif
        c_st_stop      = 3'd3,
        c_st_wait_idle = 3'd4
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_bit_cnt;
    logic [N-1:0]       r_shift;
    logic [N-1:0]       r_data_out;
    logic               r_valid;
    logic               r_frame_err;
    logic               r_overrun;
    logic               w_accept;
    logic               w_parity_ok;

`ifdef SIPO_RX_PARITY_EN
    logic               r_parity_bit;
    logic               r_parity_err;

    // Even parity over data+parity: the parity bit equals the XOR of the data.
    assign w_parity_ok = ((^r_shift) == r_parity_bit);
    assign parity_err  = r_parity_err;
`else
    assign w_parity_ok = 1'b1;
    assign parity_err  = 1'b0;
`endif

    assign w_accept  = r_valid && ready_in;
    assign busy      = (r_state != c_st_idle);
    assign data_out  = r_data_out;
    assign valid_out = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_data_out   <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
            r_parity_bit <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            // A delivery later in this cycle overrides the accept below.
            if (w_accept) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                c_st_idle: begin
                    if (!data_in) begin
                        r_state   <= c_st_data;
                        r_bit_cnt <= '0;
                    end
                end

                c_st_data: begin
                    r_shift   <= {data_in, r_shift[N-1:1]};
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (r_bit_cnt == c_last_bit) begin
`ifdef SIPO_RX_PARITY_EN
                        r_state <= c_st_parity;
`else
                        r_state <= c_st_stop;
`endif
                    end
                end

`ifdef SIPO_RX_PARITY_EN
                c_st_parity: begin
                    r_parity_bit <= data_in;
                    r_state      <= c_st_stop;
                end
`endif

                c_st_stop: begin
                    if (!data_in) begin
                        r_frame_err <= 1'b1;
                        r_state     <= c_st_wait_idle;
                    end else if (!w_parity_ok) begin
`ifdef SIPO_RX_PARITY_EN
                        r_parity_err <= 1'b1;
`endif
                        r_state <= c_st_idle;
                    end else begin
                        if (!r_valid || w_accept) begin
                            r_data_out <= r_shift;
                            r_valid    <= 1'b1;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                        r_state <= c_st_idle;
                    end
                end

                // A line stuck low after a bad stop bit is not a start bit.
                c_st_wait_idle: begin
                    if (data_in) begin
                        r_state <= c_st_idle;
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sipo_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_sipo_frame_rx
// Brief    : Randomized + directed bench for sipo_frame_rx; frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sipo_frame_rx;

    localparam int N = 8;

    typedef enum int {
        EV_IDLE, EV_START, EV_MID, EV_GOOD, EV_FERR, EV_PERR, EV_LOW
    } ev_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         data_in = 1'b1;
    logic         ready_in = 1'b1;
    logic [N-1:0] data_out;
    logic         valid_out;
    logic         busy;
    logic         frame_err;
    logic         parity_err;
    logic         overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-cycle annotation of what the driver put on the line.
    ev_t          cur_ev   = EV_IDLE;
    logic [N-1:0] cur_word = '0;
    int           ready_mode = 1;

    // Reference model state.
    logic         m_live  = 1'b0;
    logic         m_valid = 1'b0;
    logic [N-1:0] m_data  = '0;
    logic         m_busy  = 1'b0;
    logic         m_fe    = 1'b0;
    logic         m_pe    = 1'b0;
    logic         m_ov    = 1'b0;

    sipo_frame_rx #(.N(N)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame-level model: the driver tells it which frame event each edge carries.
    always @(posedge clk) begin
        m_fe = 1'b0;
        m_pe = 1'b0;
        m_ov = 1'b0;
        if (reset) begin
            m_live  = 1'b1;
            m_valid = 1'b0;
            m_data  = '0;
            m_busy  = 1'b0;
        end else begin
            if (m_valid && ready_in) m_valid = 1'b0;
            case (cur_ev)
                EV_GOOD: begin
                    if (!m_valid) begin
                        m_data  = cur_word;
                        m_valid = 1'b1;
                    end else begin
                        m_ov = 1'b1;
                    end
                    m_busy = 1'b0;
                end
                EV_FERR: begin m_fe = 1'b1; m_busy = 1'b1; end
                EV_PERR: begin m_pe = 1'b1; m_busy = 1'b0; end
                EV_START, EV_MID, EV_LOW: m_busy = 1'b1;
                default: m_busy = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("valid_out", valid_out, m_valid);
            check("data_out", data_out, m_data);
            check("busy", busy, m_busy);
            check("frame_err", frame_err, m_fe);
            check("parity_err", parity_err, m_pe);
            check("overrun", overrun, m_ov);
        end
    end

    task automatic tick(input logic b, input ev_t e, input logic [N-1:0] w = '0,
                        input logic r = 1'b0);
        @(negedge clk);
        data_in  = b;
        cur_ev   = e;
        cur_word = w;
        reset    = r;
        if (ready_mode == 2) ready_in = 1'($urandom_range(0, 1));
        else                 ready_in = (ready_mode != 0);
    endtask

    // abort_at >= 0 asserts reset in place of that data bit and ends the frame.
    task automatic send_frame(input logic [N-1:0] w, input logic stop_bit,
                              input logic par_ok, input int abort_at);
        logic bad_par;
        tick(1'b0, EV_START);
        for (int i = 0; i < N; i++) begin
            if (i == abort_at) begin
                tick(1'b1, EV_IDLE, '0, 1'b1);
                return;
            end
            tick(w[i], EV_MID);
        end
`ifdef SIPO_RX_PARITY_EN
        tick((^w) ^ !par_ok, EV_MID);
        bad_par = !par_ok;
`else
        bad_par = 1'b0;
`endif
        if (!stop_bit)    tick(1'b0, EV_FERR);
        else if (bad_par) tick(1'b1, EV_PERR);
        else              tick(1'b1, EV_GOOD, w);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, EV_IDLE);
    endtask

    task automatic hold_low(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, EV_LOW);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        tick(1'b1, EV_IDLE, '0, 1'b1);
        tick(1'b1, EV_IDLE, '0, 1'b1);
        after_edge();
        check("reset_valid", valid_out, 1'b0);
        check("reset_data", data_out, 0);
        check("reset_busy", busy, 1'b0);

        // Plain frame 0xA5
        ready_mode = 1;
        idle(3);
        send_frame(8'hA5, 1'b1, 1'b1, -1);
        after_edge();
        check("t1_valid", valid_out, 1'b1);
        check("t1_data", data_out, 8'hA5);
        idle(2);

        // Overrun while holding register is full
        ready_mode = 0;
        send_frame(8'h3C, 1'b1, 1'b1, -1);
        send_frame(8'hF0, 1'b1, 1'b1, -1);
        after_edge();
        check("t2_overrun", overrun, 1'b1);
        check("t2_data", data_out, 8'h3C);
        check("t2_valid", valid_out, 1'b1);
        ready_mode = 1;
        tick(1'b1, EV_IDLE);
        ready_mode = 0;
        idle(1);
        check("t2_drained", valid_out, 1'b0);
        idle(1);

        // Framing error, line held low, then recovery
        ready_mode = 1;
        send_frame(8'h55, 1'b0, 1'b1, -1);
        after_edge();
        check("t3_frame_err", frame_err, 1'b1);
        hold_low(5);
        check("t3_busy_low", busy, 1'b1);
        idle(1);
        send_frame(8'h81, 1'b1, 1'b1, -1);
        after_edge();
        check("t3_data", data_out, 8'h81);
        idle(1);

        // Reset mid-frame
        send_frame(8'hFF, 1'b1, 1'b1, 4);
        after_edge();
        check("t4_busy", busy, 1'b0);
        check("t4_valid", valid_out, 1'b0);
        idle(2);
        send_frame(8'h12, 1'b1, 1'b1, -1);
        after_edge();
        check("t4_data", data_out, 8'h12);
        idle(2);

`ifdef SIPO_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, -1);
        after_edge();
        check("t5_good", data_out, 8'h07);
        idle(2);
        send_frame(8'h07, 1'b1, 1'b0, -1);
        after_edge();
        check("t5_perr", parity_err, 1'b1);
        check("t5_valid", valid_out, 1'b0);
        idle(2);
`endif

        // Back-to-back frames, zero gap
        send_frame(8'h01, 1'b1, 1'b1, -1);
        after_edge();
        check("t6_first", data_out, 8'h01);
        send_frame(8'h80, 1'b1, 1'b1, -1);
        after_edge();
        check("t6_second", data_out, 8'h80);
        check("t6_no_overrun", overrun, 1'b0);
        idle(2);

        // Randomized traffic
        for (int f = 0; f < 80; f++) begin
            logic [N-1:0] w;
            logic         stop_ok;
            logic         par_ok;
            int           abort_at;
            w          = N'($urandom);
            stop_ok    = ($urandom_range(0, 7) != 0);
            par_ok     = ($urandom_range(0, 7) != 0);
            abort_at   = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, N - 1)) : -1;
            ready_mode = int'($urandom_range(0, 3) == 0 ? 0 : 2);
            send_frame(w, stop_ok, par_ok, abort_at);
            if (abort_at < 0 && !stop_ok) begin
                hold_low(int'($urandom_range(0, 4)));
                idle(1);
            end
            idle(int'($urandom_range(0, 2)));
        end
        ready_mode = 1;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
